// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: aligns stores, formats loads, stalls while a bus request is outstanding.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic        mem_rdM,
  input  logic        mem_wrM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] wdataM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] mem_out,
  output logic        stall_mem,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        access;
  logic        mis_c;
  logic        go;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] fmt_c;

  // Load formatting needs the lane, size and sign captured at issue.
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic        lat_load;

  assign access    = validM & (mem_rdM | mem_wrM);
  assign go        = (state == S_IDLE) & access & ~mis_c;
  assign misalign  = (state == S_IDLE) & access & mis_c;
  assign stall_mem = go | (state == S_BUSY);

  always_comb begin
    mis_c   = 1'b0;
    be_c    = 4'b1111;
    wdata_c = wdataM;
    unique case (funct3M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResultM[1:0];
        wdata_c = {4{wdataM[7:0]}};
      end
      2'b01: begin
        mis_c   = ALUResultM[0];
        be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdataM[15:0]}};
      end
      default: mis_c = (ALUResultM[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    fmt_c = bus_rdata;
    unique case (lat_size)
      2'b00: begin
        unique case (lat_off)
          2'd0:    fmt_c = {{24{~lat_uns & bus_rdata[7]}},  bus_rdata[7:0]};
          2'd1:    fmt_c = {{24{~lat_uns & bus_rdata[15]}}, bus_rdata[15:8]};
          2'd2:    fmt_c = {{24{~lat_uns & bus_rdata[23]}}, bus_rdata[23:16]};
          default: fmt_c = {{24{~lat_uns & bus_rdata[31]}}, bus_rdata[31:24]};
        endcase
      end
      2'b01: begin
        if (lat_off[1])
          fmt_c = {{16{~lat_uns & bus_rdata[31]}}, bus_rdata[31:16]};
        else
          fmt_c = {{16{~lat_uns & bus_rdata[15]}}, bus_rdata[15:0]};
      end
      default: fmt_c = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      mem_out   <= '0;
      lat_off   <= '0;
      lat_size  <= '0;
      lat_uns   <= 1'b0;
      lat_load  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
`ifdef LSU_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_BUSY;
            bus_req   <= 1'b1;
            bus_we    <= mem_wrM;
            bus_addr  <= {ALUResultM[31:2], 2'b00};
            bus_be    <= be_c;
            bus_wdata <= wdata_c;
            lat_off   <= ALUResultM[1:0];
            lat_size  <= funct3M[1:0];
            lat_uns   <= funct3M[2];
            lat_load  <= mem_rdM & ~mem_wrM;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= S_DONE;
            if (lat_load)
              mem_out <= fmt_c;
          end
`ifdef LSU_TIMEOUT_EN
          // Count reaches the limit on the edge that ends the last unacked BUSY cycle.
          else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a behavioural model of the access rules.
module tb_lsu_mem_stage;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, mem_rdM, mem_wrM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, wdataM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] mem_out;
  logic        stall_mem, misalign, bus_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_mem = '0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .validM(validM), .mem_rdM(mem_rdM), .mem_wrM(mem_wrM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .wdataM(wdataM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .mem_out(mem_out), .stall_mem(stall_mem), .misalign(misalign), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference: byte enables and store data from size and byte offset.
  function automatic logic [3:0] ref_be(input int unsigned n, input int unsigned off);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input int unsigned n, input logic [31:0] wd);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned n, input int unsigned off,
                                           input logic uns, input logic [31:0] word);
    logic [31:0] mask, v;
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * n)) - 1);
    v = (word >> (8 * off)) & mask;
    if (n < 4 && !uns && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive_idle();
    validM = 1'b0; mem_rdM = 1'b0; mem_wrM = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rword, input int unsigned waits,
                            input logic idle_ack);
    int unsigned n, off, stalls;
    logic mis, load, acked;
    n = size_of(f3); off = addr % 4; mis = (addr % n) != 0; load = rd & ~wr;
    @(posedge clk); #1;
    validM = 1'b1; mem_rdM = rd; mem_wrM = wr; funct3M = f3; ALUResultM = addr; wdataM = wd;
    bus_ack = idle_ack; bus_rdata = $urandom;
    @(negedge clk);
    check("idle_misalign", 32'(misalign), 32'(mis));
    check("idle_stall", 32'(stall_mem), 32'(!mis));
    check("idle_req", 32'(bus_req), 0);
    if (mis) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("mis_req", 32'(bus_req), 0);
      check("mis_memout", mem_out, exp_mem);
      return;
    end
    stalls = 1; acked = 1'b0;
    for (int unsigned c = 1; c < 64; c++) begin
      @(posedge clk); #1;
      bus_ack = (c == waits + 1);
      bus_rdata = bus_ack ? rword : $urandom;
      ALUResultM = $urandom; wdataM = $urandom; funct3M = 3'($urandom);
      @(negedge clk);
      if (!stall_mem) begin
        acked = 1'b1;
        break;
      end
      stalls++;
      check("busy_req", 32'(bus_req), 1);
      check("busy_we", 32'(bus_we), 32'(wr));
      check("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
      check("busy_be", 32'(bus_be), 32'(ref_be(n, off)));
      if (wr) check("busy_wdata", bus_wdata, ref_wdata(n, wd));
      check("busy_misalign", 32'(misalign), 0);
      check("busy_err", 32'(bus_err), 0);
    end
    check("done_reached", 32'(acked), 1);
    if (load) exp_mem = ref_load(n, off, f3[2], rword);
    check("stall_cycles", stalls, waits + 2);
    check("done_req", 32'(bus_req), 0);
    check("done_memout", mem_out, exp_mem);
  endtask

  task automatic run_nonaccess();
    @(posedge clk); #1;
    validM = 1'($urandom);
    mem_rdM = validM ? 1'b0 : 1'($urandom);
    mem_wrM = validM ? 1'b0 : 1'($urandom);
    funct3M = 3'($urandom); ALUResultM = $urandom; bus_ack = 1'($urandom);
    @(negedge clk);
    check("nop_stall", 32'(stall_mem), 0);
    check("nop_misalign", 32'(misalign), 0);
    check("nop_req", 32'(bus_req), 0);
    check("nop_memout", mem_out, exp_mem);
  endtask

  task automatic run_reset_in_busy();
    @(posedge clk); #1;
    validM = 1'b1; mem_rdM = 1'b1; mem_wrM = 1'b0; funct3M = 3'b010;
    ALUResultM = 32'h0000_0500; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_busy1_req", 32'(bus_req), 1);
    @(posedge clk); #1;
    rst = 1'b1; validM = 1'b0; mem_rdM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    exp_mem = '0;
    check("rst_req", 32'(bus_req), 0);
    check("rst_stall", 32'(stall_mem), 0);
    check("rst_memout", mem_out, exp_mem);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic run_timeout();
    int unsigned busy;
    logic done;
    @(posedge clk); #1;
    validM = 1'b1; mem_rdM = 1'b1; mem_wrM = 1'b0; funct3M = 3'b010;
    ALUResultM = 32'h0000_0600; bus_ack = 1'b0;
    busy = 0; done = 1'b0;
    for (int unsigned c = 1; c < 64; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!stall_mem) begin
        done = 1'b1;
        break;
      end
      busy++;
      check("tmo_busy_err", 32'(bus_err), 0);
    end
    check("tmo_done", 32'(done), 1);
    check("tmo_busy_cycles", busy, TMO);
    check("tmo_err_pulse", 32'(bus_err), 1);
    check("tmo_req", 32'(bus_req), 0);
    check("tmo_memout", mem_out, exp_mem);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("tmo_err_clear", 32'(bus_err), 0);
    check("tmo_idle_stall", 32'(stall_mem), 0);
  endtask
`endif

  initial begin
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr;
    int unsigned n;
    rst = 1'b1;
    drive_idle();
    funct3M = '0; ALUResultM = '0; wdataM = '0; bus_rdata = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_bus_we", 32'(bus_we), 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", 32'(bus_be), 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_stall", 32'(stall_mem), 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b0;

    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check("lb_value", mem_out, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_0000, 3, 1'b1);
    check("lhu_value", mem_out, 32'h0000_BEEF);
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56AB, 32'h0, 1, 1'b0);
    check("sb_memout_kept", mem_out, 32'h0000_BEEF);
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'h0, 32'h0, 0, 1'b0);
    run_reset_in_busy();
`ifdef LSU_TIMEOUT_EN
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0702, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    run_timeout();
`endif

    for (int unsigned i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_nonaccess();
      end else begin
        rd = 1'($urandom); wr = 1'($urandom);
        if (!rd && !wr) rd = 1'b1;
        f3 = 3'($urandom);
        n = size_of(f3);
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
        run_access(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 2), 1'($urandom));
      end
    end

    @(posedge clk); #1;
    drive_idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
